// File: rtl/fp_pkg.sv
// Shared definitions for the sign-less single-precision datapath.
//   FP_EXP_W / FP_MANT_W : field widths of a 31-bit {exp, mant} operand
//   FP_EXP_MAX           : saturated exponent value used on overflow
//   fp31_t               : packed {exp, mant} view of an operand
//   add_state_t          : control states of the sequential adder
package fp_pkg;

    localparam int FP_EXP_W  = 8;
    localparam int FP_MANT_W = 23;
    localparam logic [FP_EXP_W-1:0] FP_EXP_MAX = 8'hFF;

    typedef struct packed {
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_MANT_W-1:0] mant;
    } fp31_t;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        DONE
    } add_state_t;

endpackage

// File: rtl/fp_unpack.sv
// Combinational operand unpacker.
//   op   : 31-bit {exp, mant} operand
//   exp  : biased exponent, passed through
//   mant : 24-bit significand with hidden bit; zero when exp==0 (denormals flushed)
module fp_unpack
    import fp_pkg::*;
(
    input  logic [30:0]          op,
    output logic [FP_EXP_W-1:0]  exp,
    output logic [FP_MANT_W:0]   mant
);

    fp31_t f;

    assign f    = fp31_t'(op);
    assign exp  = f.exp;
    assign mant = (f.exp == '0) ? '0 : {1'b1, f.mant};

endmodule

// File: rtl/unsigned_floating_point_adder_seq.sv
// Multi-cycle adder for two positive single-precision values without sign bit.
// The smaller operand is aligned one bit per clock, then added and renormalised
// with truncation. One transaction in flight, valid/ready on both sides.
//   clk, rst_n           : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (in_ready high only when idle)
//   a, b                 : operands {exp[30:23], mant[22:0]}
//   out_valid / out_ready: result handshake
//   out                  : sum {exp, mant}
//   overflow             : exponent saturated to 8'hFF, qualified by out_valid
module unsigned_floating_point_adder_seq
    import fp_pkg::*;
#(
    parameter int MAX_ALIGN = 24
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [30:0] a,
    input  logic [30:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [30:0] out,
    output logic        overflow
);

    localparam int CNT_W = $clog2(MAX_ALIGN + 1);

    // Result formatting: returns {overflow, out}. A carry out of the sum
    // bumps the exponent; reaching the all-ones exponent saturates.
    function automatic logic [31:0] normalize(input logic [FP_MANT_W+1:0] s,
                                              input logic [FP_EXP_W-1:0]  e);
        if (s == '0)
            return 32'h0;
        if (s[FP_MANT_W+1]) begin
            if (e >= FP_EXP_MAX - 8'd1)
                return {1'b1, FP_EXP_MAX, {FP_MANT_W{1'b0}}};
            return {1'b0, e + 8'd1, s[FP_MANT_W:1]};
        end
        return {1'b0, e, s[FP_MANT_W-1:0]};
    endfunction

    add_state_t state, state_nxt;

    logic [FP_EXP_W-1:0]  a_exp, b_exp, big_exp, small_exp, exp_diff;
    logic [FP_MANT_W:0]   a_man, b_man, big_man, small_man;
    logic                 swap, gap_capped;

    logic [FP_EXP_W-1:0]  exp_a_r;
    logic [FP_MANT_W:0]   man_a_r, man_b_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [FP_MANT_W+1:0] sum_r;

    fp_unpack u_unpack_a (.op(a), .exp(a_exp), .mant(a_man));
    fp_unpack u_unpack_b (.op(b), .exp(b_exp), .mant(b_man));

    // Larger exponent becomes A; equal exponents keep the original order.
    assign swap       = b_exp > a_exp;
    assign big_exp    = swap ? b_exp : a_exp;
    assign small_exp  = swap ? a_exp : b_exp;
    assign big_man    = swap ? b_man : a_man;
    assign small_man  = swap ? a_man : b_man;
    assign exp_diff   = big_exp - small_exp;
    assign gap_capped = exp_diff > 8'(MAX_ALIGN);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = ALIGN;
            ALIGN:   if (cnt_r == '0) state_nxt = ADD;
            ADD:     state_nxt = NORM;
            NORM:    state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers: only meaningful once the FSM has captured operands.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (in_valid) begin
                    exp_a_r <= big_exp;
                    man_a_r <= big_man;
                    // A gap beyond the cap would shift B out completely anyway.
                    man_b_r <= gap_capped ? '0 : small_man;
                    cnt_r   <= gap_capped ? CNT_W'(MAX_ALIGN) : CNT_W'(exp_diff);
                end
            end
            ALIGN: begin
                if (cnt_r != '0) begin
                    man_b_r <= man_b_r >> 1;
                    cnt_r   <= cnt_r - 1'b1;
                end
            end
            ADD: sum_r <= {1'b0, man_a_r} + {1'b0, man_b_r};
            default: ;
        endcase
    end

    // Result registers hold until the next NORM, so they stay stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out      <= '0;
            overflow <= 1'b0;
        end else if (state == NORM) begin
            {overflow, out} <= normalize(sum_r, exp_a_r);
        end
    end

endmodule

// File: tb/tb_unsigned_floating_point_adder_seq.sv
module tb_unsigned_floating_point_adder_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [30:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [30:0] out;
    logic        overflow;

    int n_pass  = 0;
    int n_total = 0;

    unsigned_floating_point_adder_seq #(.MAX_ALIGN(24)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [30:0] a;
        logic [30:0] b;
        logic [30:0] out;
        logic        ovf;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, want);
    endtask

    // Reference: exact value A*2^d + B, truncated to a 24-bit significand.
    function automatic void model(input logic [30:0] x, input logic [30:0] y,
                                  output logic [30:0] o, output logic ov, output int lat);
        int ea, eb, d, t;
        longint unsigned ma, mb, tot, q;
        ea = int'(x[30:23]);
        eb = int'(y[30:23]);
        ma = (ea == 0) ? 0 : (longint'(1) << 23) + longint'(x[22:0]);
        mb = (eb == 0) ? 0 : (longint'(1) << 23) + longint'(y[22:0]);
        if (eb > ea) begin
            t = ea; ea = eb; eb = t;
            q = ma; ma = mb; mb = q;
        end
        d = ea - eb;
        lat = ((d > 24) ? 24 : d) + 3;
        if (d > 24) begin
            tot = ma;
            d = 0;
        end else begin
            tot = (ma << d) + mb;
        end
        ov = 1'b0;
        if (tot == 0) begin
            o = '0;
        end else if ((tot >> (24 + d)) != 0) begin
            if (ea >= 254) begin
                o = {8'hFF, 23'h0};
                ov = 1'b1;
            end else begin
                q = tot >> (d + 1);
                o = {8'(ea + 1), q[22:0]};
            end
        end else begin
            q = tot >> d;
            o = {8'(ea), q[22:0]};
        end
    endfunction

    // Present operands, wait for out_valid; ends #1 after the edge where it rose.
    task automatic start_and_wait(input logic [30:0] x, input logic [30:0] y,
                                  output logic [30:0] o, output logic ov, output int lat);
        @(negedge clk);
        a = x; b = y; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = -1;
        o = 'x; ov = 1'bx;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = k;
                o = out;
                ov = overflow;
                break;
            end
        end
        if (lat < 0) $display("FAIL timeout: out_valid never rose for a=%h b=%h", x, y);
    endtask

    vec_t vecs[7];

    initial begin
        logic [30:0] o, hold, ra, rb, mo;
        logic        ov, mov;
        int          lat, mlat, ea, eb;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        #12;
        check("reset out", {1'b0, out}, 32'h0);
        check("reset overflow", {31'h0, overflow}, 32'h0);
        check("reset out_valid", {31'h0, out_valid}, 32'h0);
        check("reset in_ready", {31'h0, in_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        vecs[0] = '{31'h3F800000, 31'h3F800000, 31'h40000000, 1'b0, 3};
        vecs[1] = '{31'h3F800000, 31'h3F000000, 31'h3FC00000, 1'b0, 4};
        vecs[2] = '{31'h3F000000, 31'h3F800000, 31'h3FC00000, 1'b0, 4};
        vecs[3] = '{31'h3F800000, 31'h30800000, 31'h3F800000, 1'b0, 27};
        vecs[4] = '{31'h7F7FFFFF, 31'h7F7FFFFF, 31'h7F800000, 1'b1, 3};
        vecs[5] = '{31'h00000000, 31'h00000000, 31'h00000000, 1'b0, 3};
        vecs[6] = '{31'h00000000, 31'h3F800000, 31'h3F800000, 1'b0, 27};

        foreach (vecs[i]) begin
            start_and_wait(vecs[i].a, vecs[i].b, o, ov, lat);
            check($sformatf("vec%0d out", i), {1'b0, o}, {1'b0, vecs[i].out});
            check($sformatf("vec%0d overflow", i), {31'h0, ov}, {31'h0, vecs[i].ovf});
            check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d out_valid drop", i), {31'h0, out_valid}, 32'h0);
        end

        // Backpressure: result held, inputs ignored while DONE.
        @(negedge clk);
        out_ready = 1'b0;
        start_and_wait(31'h3F800000, 31'h3F000000, hold, ov, lat);
        check("bp first out", {1'b0, hold}, {1'b0, 31'h3FC00000});
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            a = 31'h7F7FFFFF; b = 31'h7F7FFFFF; in_valid = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("bp%0d out stable", k), {1'b0, out}, {1'b0, hold});
            check($sformatf("bp%0d out_valid", k), {31'h0, out_valid}, 32'h1);
            check($sformatf("bp%0d in_ready", k), {31'h0, in_ready}, 32'h0);
            in_valid = 1'b0;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp release out_valid", {31'h0, out_valid}, 32'h0);
        check("bp release in_ready", {31'h0, in_ready}, 32'h1);
        check("bp overflow held", {31'h0, overflow}, 32'h0);
        @(posedge clk);
        #1;
        check("bp idle after release", {31'h0, in_ready}, 32'h1);

        // Asynchronous reset in the middle of a long alignment.
        @(negedge clk);
        a = 31'h3F800000; b = 31'h30800000; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset out_valid", {31'h0, out_valid}, 32'h0);
        check("midreset in_ready", {31'h0, in_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (out_valid) break;
        end
        check("no result after abort", {31'h0, out_valid}, 32'h0);
        start_and_wait(31'h3F800000, 31'h3F800000, o, ov, lat);
        check("post reset out", {1'b0, o}, {1'b0, 31'h40000000});
        check("post reset latency", lat, 3);
        @(posedge clk);

        // Randomised operands against the reference model.
        for (int n = 0; n < 200; n++) begin
            ea = int'($urandom_range(0, 254));
            case ($urandom_range(0, 3))
                0: eb = ea;
                1: eb = ea - int'($urandom_range(0, 30));
                2: eb = ea + int'($urandom_range(0, 30));
                default: eb = int'($urandom_range(0, 254));
            endcase
            if (eb < 0) eb = 0;
            if (eb > 254) eb = 254;
            if ($urandom_range(0, 15) == 0) ea = 0;
            ra = {8'(ea), 23'($urandom)};
            rb = {8'(eb), 23'($urandom)};
            model(ra, rb, mo, mov, mlat);
            start_and_wait(ra, rb, o, ov, lat);
            check($sformatf("rnd%0d out a=%h b=%h", n, ra, rb), {1'b0, o}, {1'b0, mo});
            check($sformatf("rnd%0d overflow", n), {31'h0, ov}, {31'h0, mov});
            check($sformatf("rnd%0d latency", n), lat, mlat);
            @(posedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/unsigned_floating_point_adder_seq.md
Name: unsigned_floating_point_adder_seq

Overview:
- Multi-cycle adder for two positive single-precision floats supplied without their sign bit (31 bits each: exponent[30:23], mantissa[22:0]).
- Unlike the combinational subtract path, exponents need not match on entry: the block aligns the operands itself, shifting the smaller operand one bit per clock, then adds and renormalises.
- Accepts operands and returns results over valid/ready handshakes, one transaction in flight.
- Sits beside the subtract path in the FP datapath, which will select add or subtract by operand signs.

Parameters:
- MAX_ALIGN, 24, cap on alignment shifts. An exponent difference above this zeroes the smaller mantissa immediately.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  a/b valid.
- in_ready  output  1  block can accept operands.
- a  input  31  operand A {exp, mant}.
- b  input  31  operand B {exp, mant}.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out  output  31  sum {exp, mant}.
- overflow  output  1  result exponent saturated to 8'hFF; valid with out_valid.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, out=0, overflow=0, out_valid=0, in_ready=1.
- Reset mid-operation aborts the transaction; nothing is emitted.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready, unpack and register both operands; go to ALIGN.
  - ALIGN: if cnt>0, mB>>=1 and cnt--; when cnt==0, go to ADD.
  - ADD: sum[24:0]=mA+mB; go to NORM.
  - NORM: compute out and overflow (rules below); go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- in_ready is low in every state except IDLE. in_valid is ignored outside IDLE.
- Unpack rules:
  - Operand with exp==0 is treated as zero: 24-bit mantissa=0. Denormals are flushed.
  - Otherwise mantissa={1'b1, mant}.
  - Swap so the larger-exponent operand is A; on equal exponents, A stays A.
  - cnt=min(expA-expB, MAX_ALIGN); if expA-expB>MAX_ALIGN, mB=0 at entry.
- Latency: with accept at edge N, out_valid rises at edge N+cnt+3 (ALIGN lasts cnt+1 cycles).
- Result (NORM):
  - sum==0: out=31'h0, overflow=0.
  - sum[24]=1: mant=sum[23:1] (truncate), exp=expA+1. If expA+1==8'hFF: out={8'hFF,23'h0}, overflow=1.
  - Otherwise: mant=sum[22:0], exp=expA.
- Rounding is truncation only. Shifted-out bits are discarded.
- out and overflow are registered and held stable while out_valid && !out_ready.
- out_valid drops the cycle after the out_ready handshake. overflow keeps its value until the next NORM.
- Back-to-back transactions: at least one IDLE cycle between transactions. No acceptance in the DONE→IDLE cycle.

Decomposition:
- Package fp_pkg:
  - Constants FP_EXP_W=8, FP_MANT_W=23, FP_EXP_MAX=8'hFF.
  - typedef fp31_t (packed struct {exp, mant}).
  - typedef add_state_t enum {IDLE, ALIGN, ADD, NORM, DONE}.
- One sub-module, fp_unpack (combinational): applies the hidden bit and zero-flush rules. Instantiated twice.
- FSM, shifter and adder live in the top module.

Test Plan:
- 1.0+1.0: a=31'h3F800000, b=31'h3F800000 → out=31'h40000000, overflow=0, out_valid at N+3.
- 1.0+0.5: a=31'h3F800000, b=31'h3F000000 → out=31'h3FC00000, out_valid at N+4. Swapped operands give an identical result.
- Large gap: a=31'h3F800000, b=31'h30800000 (diff 30, capped to 24) → out=31'h3F800000, out_valid at N+27.
- Overflow: a=b=31'h7F7FFFFF → out=31'h7F800000, overflow=1. Also 0+0 → out=0, overflow=0. Also a=0, b=31'h3F800000 → out=31'h3F800000.
- Backpressure: out_ready held low 5 cycles after out_valid → out stable, in_ready=0, in_valid pulses ignored. out_ready=1 → out_valid low next cycle, in_ready=1.
- Reset mid-ALIGN: rst_n low during the diff-30 case → out_valid=0 and in_ready=1 immediately (asynchronous). After release, a fresh 1.0+1.0 yields 31'h40000000.
